// File: rtl/tiny_alu_requester_if.sv
// rtl/tiny_alu_requester_if.sv - command, ALU and response signals of the tiny ALU requester
interface tiny_alu_requester_if #(
   parameter int INPUT_DATA_BITS = 8,
   parameter int OPCODE_BITS     = 3
);
   logic                           cmd_valid_i;
   logic                           cmd_ready_o;
   logic [INPUT_DATA_BITS-1:0]     cmd_a_i;
   logic [INPUT_DATA_BITS-1:0]     cmd_b_i;
   logic [OPCODE_BITS-1:0]         cmd_op_i;
   logic [INPUT_DATA_BITS-1:0]     alu_a_o;
   logic [INPUT_DATA_BITS-1:0]     alu_b_o;
   logic [OPCODE_BITS-1:0]         alu_opcode_o;
   logic                           alu_start_o;
   logic [2*INPUT_DATA_BITS-1:0]   alu_result_i;
   logic                           alu_done_i;
   logic                           rsp_valid_o;
   logic                           rsp_ready_i;
   logic [2*INPUT_DATA_BITS-1:0]   rsp_result_o;
   logic [OPCODE_BITS-1:0]         rsp_op_o;
   logic                           rsp_timeout_o;
   logic                           busy_o;

   // master is the requester itself; slave is the command source / ALU / response sink side
   modport master (
      input  cmd_valid_i, cmd_a_i, cmd_b_i, cmd_op_i, alu_result_i, alu_done_i, rsp_ready_i,
      output cmd_ready_o, alu_a_o, alu_b_o, alu_opcode_o, alu_start_o,
             rsp_valid_o, rsp_result_o, rsp_op_o, rsp_timeout_o, busy_o
   );

   modport slave (
      output cmd_valid_i, cmd_a_i, cmd_b_i, cmd_op_i, alu_result_i, alu_done_i, rsp_ready_i,
      input  cmd_ready_o, alu_a_o, alu_b_o, alu_opcode_o, alu_start_o,
             rsp_valid_o, rsp_result_o, rsp_op_o, rsp_timeout_o, busy_o
   );
endinterface

// File: rtl/tiny_alu_requester.sv
// rtl/tiny_alu_requester.sv - start/done initiator for the tiny ALU with response stream and timeout
module tiny_alu_requester #(
   parameter int INPUT_DATA_BITS = 8,
   parameter int OPCODE_BITS     = 3,
   parameter int TIMEOUT_CYCLES  = 16
) (
   input logic                  clk_i,
   input logic                  reset_i,
   tiny_alu_requester_if.master bus
);
   localparam int RES_BITS = 2 * INPUT_DATA_BITS;
   localparam int CNT_BITS = $clog2(TIMEOUT_CYCLES);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_NOP   = 2'd1;
   localparam logic [1:0] ST_ISSUE = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   localparam logic [OPCODE_BITS-1:0] OP_NOP = '0;
   localparam logic [OPCODE_BITS-1:0] OP_RST = OPCODE_BITS'(7);
   localparam logic [CNT_BITS-1:0]    CNT_LAST = CNT_BITS'(TIMEOUT_CYCLES - 1);

   logic [1:0]                 state_q, state_d;
   logic [CNT_BITS-1:0]        cnt_q, cnt_d;
   logic [INPUT_DATA_BITS-1:0] a_q, a_d;
   logic [INPUT_DATA_BITS-1:0] b_q, b_d;
   logic [OPCODE_BITS-1:0]     op_q, op_d;
   logic                       start_q, start_d;
   logic [RES_BITS-1:0]        result_q, result_d;
   logic                       timeout_q, timeout_d;
   logic                       rsp_valid_q, rsp_valid_d;
   logic                       cmd_ready_q, cmd_ready_d;
   logic                       busy_q, busy_d;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      start_d     = 1'b0;
      result_d    = result_q;
      timeout_d   = timeout_q;
      rsp_valid_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.cmd_valid_i && cmd_ready_q) begin
               a_d     = bus.cmd_a_i;
               b_d     = bus.cmd_b_i;
               op_d    = bus.cmd_op_i;
               start_d = 1'b1;
               if (bus.cmd_op_i == OP_NOP || bus.cmd_op_i == OP_RST) begin
                  state_d = ST_NOP;
               end else begin
                  state_d = ST_ISSUE;
                  cnt_d   = '0;
               end
            end
         end
         ST_NOP: begin
            state_d = ST_IDLE;
         end
         ST_ISSUE: begin
            // done takes priority over an expiring counter on the same edge
            if (bus.alu_done_i) begin
               result_d    = bus.alu_result_i;
               timeout_d   = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = ST_RESP;
            end else if (cnt_q == CNT_LAST) begin
               result_d    = '0;
               timeout_d   = 1'b1;
               rsp_valid_d = 1'b1;
               state_d     = ST_RESP;
            end else begin
               cnt_d   = cnt_q + CNT_BITS'(1);
               start_d = 1'b1;
            end
         end
         default: begin
            if (bus.rsp_ready_i) begin
               state_d = ST_IDLE;
            end else begin
               rsp_valid_d = 1'b1;
            end
         end
      endcase

      cmd_ready_d = (state_d == ST_IDLE);
      busy_d      = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         start_q     <= 1'b0;
         result_q    <= '0;
         timeout_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         cmd_ready_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         start_q     <= start_d;
         result_q    <= result_d;
         timeout_q   <= timeout_d;
         rsp_valid_q <= rsp_valid_d;
         cmd_ready_q <= cmd_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.cmd_ready_o   = cmd_ready_q;
   assign bus.alu_a_o       = a_q;
   assign bus.alu_b_o       = b_q;
   assign bus.alu_opcode_o  = op_q;
   assign bus.alu_start_o   = start_q;
   assign bus.rsp_valid_o   = rsp_valid_q;
   assign bus.rsp_result_o  = result_q;
   assign bus.rsp_op_o      = op_q;
   assign bus.rsp_timeout_o = timeout_q;
   assign bus.busy_o        = busy_q;
endmodule

// File: tb/tb_tiny_alu_requester.sv
// tb/tb_tiny_alu_requester.sv - directed table-driven bench for tiny_alu_requester with a latency-programmable ALU model
module tb_tiny_alu_requester;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   alu_lat = 0;
   int   alu_cnt = 0;
   logic st_s;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [2:0]  op;
      int          lat;
      int          hold;
      logic [15:0] exp_result;
      logic        exp_to;
      logic        exp_rsp;
      int          exp_starts;
   } vec_t;

   vec_t vecs [10];

   tiny_alu_requester_if #(.INPUT_DATA_BITS(8), .OPCODE_BITS(3)) bus ();

   tiny_alu_requester #(.INPUT_DATA_BITS(8), .OPCODE_BITS(3), .TIMEOUT_CYCLES(16)) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
      case (op)
         3'd1:    return {8'h00, a} + {8'h00, b};
         3'd2:    return {8'h00, a} - {8'h00, b};
         3'd3:    return {8'h00, a ^ b};
         3'd4:    return {8'h00, a} * {8'h00, b};
         3'd5:    return {8'h00, a & b};
         3'd6:    return {8'h00, a | b};
         default: return 16'h0000;
      endcase
   endfunction

   // ALU model: done pulses alu_lat cycles after start is first seen high (alu_lat 0 = never)
   always begin
      @(posedge clk);
      st_s = bus.alu_start_o;
      #1;
      if (st_s && alu_lat != 0) begin
         alu_cnt = alu_cnt + 1;
         bus.alu_done_i   = (alu_cnt == alu_lat);
         bus.alu_result_i = (alu_cnt == alu_lat) ? alu_f(bus.alu_a_o, bus.alu_b_o, bus.alu_opcode_o) : 16'hDEAD;
      end else begin
         alu_cnt          = 0;
         bus.alu_done_i   = 1'b0;
         bus.alu_result_i = 16'hDEAD;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic wait_rsp(input string name);
      int cyc = 0;
      while (!bus.rsp_valid_o && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      chk({name, "_rsp_seen"}, bus.rsp_valid_o, 1);
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int    cyc;
      int    starts;
      logic  seen;
      string t;
      t = $sformatf("v%0d", idx);
      alu_lat = v.lat;
      @(negedge clk);
      bus.cmd_a_i     = v.a;
      bus.cmd_b_i     = v.b;
      bus.cmd_op_i    = v.op;
      bus.cmd_valid_i = 1'b1;
      cyc = 0;
      while (!bus.cmd_ready_o && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk({t, "_cmd_ready"}, bus.cmd_ready_o, 1);
      @(negedge clk);
      bus.cmd_valid_i = 1'b0;
      chk({t, "_alu_a"}, bus.alu_a_o, v.a);
      chk({t, "_alu_op"}, bus.alu_opcode_o, v.op);
      starts = 0;
      seen   = 1'b0;
      cyc    = 0;
      while (cyc < 40) begin
         if (bus.alu_start_o) starts++;
         if (bus.rsp_valid_o) begin
            seen = 1'b1;
            break;
         end
         if (!bus.busy_o) break;
         @(negedge clk);
         cyc++;
      end
      chk({t, "_start_cycles"}, starts, v.exp_starts);
      chk({t, "_rsp_seen"}, seen, v.exp_rsp);
      if (seen) begin
         chk({t, "_result"}, bus.rsp_result_o, v.exp_result);
         chk({t, "_rsp_op"}, bus.rsp_op_o, v.op);
         chk({t, "_timeout"}, bus.rsp_timeout_o, v.exp_to);
         for (int k = 0; k < v.hold; k++) begin
            @(negedge clk);
            chk({t, "_hold_valid"}, bus.rsp_valid_o, 1);
            chk({t, "_hold_result"}, bus.rsp_result_o, v.exp_result);
            chk({t, "_hold_start"}, bus.alu_start_o, 0);
         end
         bus.rsp_ready_i = 1'b1;
         @(negedge clk);
         bus.rsp_ready_i = 1'b0;
         chk({t, "_valid_cleared"}, bus.rsp_valid_o, 0);
      end
      chk({t, "_idle_ready"}, bus.cmd_ready_o, 1);
   endtask

   initial begin
      int cnt;
      vecs[0] = '{8'hFF, 8'h01, 3'd1,  1, 0, 16'h0100, 1'b0, 1'b1,  2};
      vecs[1] = '{8'hFF, 8'hFF, 3'd4,  3, 1, 16'hFE01, 1'b0, 1'b1,  4};
      vecs[2] = '{8'h01, 8'h02, 3'd0,  1, 0, 16'h0000, 1'b0, 1'b0,  1};
      vecs[3] = '{8'h03, 8'h04, 3'd7,  1, 0, 16'h0000, 1'b0, 1'b0,  1};
      vecs[4] = '{8'h12, 8'h34, 3'd2,  0, 2, 16'h0000, 1'b1, 1'b1, 16};
      vecs[5] = '{8'h12, 8'h34, 3'd1,  2, 3, 16'h0046, 1'b0, 1'b1,  3};
      vecs[6] = '{8'hA5, 8'h0F, 3'd3,  1, 0, 16'h00AA, 1'b0, 1'b1,  2};
      vecs[7] = '{8'hF0, 8'h3C, 3'd5, 15, 1, 16'h0030, 1'b0, 1'b1, 16};
      vecs[8] = '{8'h0F, 8'hF0, 3'd6, 16, 2, 16'h0000, 1'b1, 1'b1, 16};
      vecs[9] = '{8'h10, 8'h01, 3'd2,  1, 0, 16'h000F, 1'b0, 1'b1,  2};

      reset           = 1'b1;
      bus.cmd_valid_i = 1'b0;
      bus.cmd_a_i     = '0;
      bus.cmd_b_i     = '0;
      bus.cmd_op_i    = '0;
      bus.rsp_ready_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", bus.cmd_ready_o, 0);
      chk("rst_start", bus.alu_start_o, 0);
      chk("rst_rsp_valid", bus.rsp_valid_o, 0);
      chk("rst_outputs", {bus.alu_a_o, bus.alu_b_o, bus.alu_opcode_o, bus.rsp_timeout_o, bus.busy_o}, 0);
      chk("rst_result", bus.rsp_result_o, 0);
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", bus.cmd_ready_o, 1);

      for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

      // NO_OP then RST back-to-back: one start pulse each, separated by a low cycle
      alu_lat = 1;
      @(negedge clk);
      bus.cmd_a_i = 8'h01; bus.cmd_b_i = 8'h02; bus.cmd_op_i = 3'd0; bus.cmd_valid_i = 1'b1;
      chk("b2b_ready0", bus.cmd_ready_o, 1);
      @(negedge clk);
      chk("b2b_start_nop", bus.alu_start_o, 1);
      chk("b2b_busy_nop", bus.cmd_ready_o, 0);
      bus.cmd_op_i = 3'd7;
      @(negedge clk);
      chk("b2b_gap_start", bus.alu_start_o, 0);
      chk("b2b_gap_ready", bus.cmd_ready_o, 1);
      @(negedge clk);
      bus.cmd_valid_i = 1'b0;
      chk("b2b_start_rst", bus.alu_start_o, 1);
      chk("b2b_op_rst", bus.alu_opcode_o, 7);
      chk("b2b_no_rsp1", bus.rsp_valid_o, 0);
      @(negedge clk);
      chk("b2b_end_start", bus.alu_start_o, 0);
      chk("b2b_no_rsp2", bus.rsp_valid_o, 0);

      // response back-pressure with a second command pending
      @(negedge clk);
      bus.cmd_a_i = 8'h20; bus.cmd_b_i = 8'h05; bus.cmd_op_i = 3'd1; bus.cmd_valid_i = 1'b1;
      chk("pend_ready0", bus.cmd_ready_o, 1);
      @(negedge clk);
      bus.cmd_a_i = 8'h02; bus.cmd_b_i = 8'h03; bus.cmd_op_i = 3'd4;
      wait_rsp("pend1");
      chk("pend1_result", bus.rsp_result_o, 16'h0025);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("pend_hold_result", bus.rsp_result_o, 16'h0025);
         chk("pend_hold_op", bus.rsp_op_o, 1);
         chk("pend_hold_ready", bus.cmd_ready_o, 0);
         chk("pend_hold_start", bus.alu_start_o, 0);
      end
      bus.rsp_ready_i = 1'b1;
      @(negedge clk);
      bus.rsp_ready_i = 1'b0;
      chk("pend_valid_clr", bus.rsp_valid_o, 0);
      chk("pend_ready1", bus.cmd_ready_o, 1);
      @(negedge clk);
      bus.cmd_valid_i = 1'b0;
      chk("pend2_start", bus.alu_start_o, 1);
      chk("pend2_a", bus.alu_a_o, 8'h02);
      chk("pend2_op", bus.alu_opcode_o, 4);
      wait_rsp("pend2");
      chk("pend2_result", bus.rsp_result_o, 16'h0006);
      bus.rsp_ready_i = 1'b1;
      @(negedge clk);
      bus.rsp_ready_i = 1'b0;

      // reset pulse during ISSUE of a MUL drops the command
      alu_lat = 3;
      @(negedge clk);
      bus.cmd_a_i = 8'hFF; bus.cmd_b_i = 8'hFF; bus.cmd_op_i = 3'd4; bus.cmd_valid_i = 1'b1;
      @(negedge clk);
      bus.cmd_valid_i = 1'b0;
      chk("mrst_start_before", bus.alu_start_o, 1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mrst_start", bus.alu_start_o, 0);
      chk("mrst_valid", bus.rsp_valid_o, 0);
      chk("mrst_busy", bus.busy_o, 0);
      chk("mrst_ready_low", bus.cmd_ready_o, 0);
      chk("mrst_alu_a", bus.alu_a_o, 0);
      @(negedge clk);
      chk("mrst_ready_high", bus.cmd_ready_o, 1);
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
         if (bus.rsp_valid_o || bus.alu_start_o) cnt++;
         @(negedge clk);
      end
      chk("mrst_no_activity", cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end
endmodule
